// File: rtl/l1c_axi_pkg.sv
// Shared definitions for the L1 cache AXI read arbiter.
// Contents:
//   state_e         - arbiter FSM states (IDLE / AR / R)
//   AXI_BURST_INCR  - AXI ARBURST encoding for incrementing bursts
//   RESP_*          - AXI RRESP encodings
package l1c_axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin picker.
// Ports:
//   i_req         - request vector, one bit per requester
//   i_ptr         - index of the highest-priority requester this round
//   o_grant       - one-hot grant (all zero when nobody requests)
//   o_grant_idx   - binary index of the granted requester
//   o_grant_valid - at least one requester is asking
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [PTR_W-1:0]   o_grant_idx,
  output logic               o_grant_valid
);

  logic [PTR_W-1:0] w_idx;
  logic             w_found;

  // Walk the requesters starting at i_ptr and wrapping; the first one
  // asking wins.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = PTR_W'((32'(i_ptr) + 32'(unsigned'(i))) % NUM_REQ);
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = w_idx;
      end
    end
    o_grant_valid = w_found;
  end

endmodule

// File: rtl/l1c_axi_read_arbiter.sv
// Merges NUM_REQ L1 refill requesters onto a single AXI4 read master.
// One burst is outstanding at a time; the owner is chosen round-robin and
// its index is used as ARID. The R channel is a zero-latency pass-through
// to the owning requester, with per-beat error reporting.
// Ports:
//   ACLK, ARESETn                 - clock, async active-low reset
//   req_valid/ready/addr/len      - per-requester refill request
//   rsp_valid/ready/data/last/err - per-requester beat return (data shared)
//   AR*, R*                       - AXI4 read address / read data channels
module l1c_axi_read_arbiter
  import l1c_axi_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 4,
  parameter int LEN_W   = 4
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_last,
  output logic                      rsp_err,
  output logic [ID_W-1:0]           ARID,
  output logic [ADDR_W-1:0]         ARADDR,
  output logic [LEN_W-1:0]          ARLEN,
  output logic [2:0]                ARSIZE,
  output logic [1:0]                ARBURST,
  output logic                      ARVALID,
  input  logic                      ARREADY,
  input  logic [ID_W-1:0]           RID,
  input  logic [DATA_W-1:0]         RDATA,
  input  logic [1:0]                RRESP,
  input  logic                      RLAST,
  input  logic                      RVALID,
  output logic                      RREADY
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SIZE  = $clog2(DATA_W / 8);
  // Clears the byte-within-beat bits so bursts start beat-aligned.
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'((1 << SIZE) - 1);

  state_e             r_state;
  state_e             w_next_state;
  logic [PTR_W-1:0]   r_owner;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [ADDR_W-1:0]  r_addr;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_beat_cnt;

  logic [NUM_REQ-1:0] w_grant;
  logic [PTR_W-1:0]   w_grant_idx;
  logic               w_grant_valid;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [LEN_W-1:0]   w_sel_len;
  logic               w_accept;
  logic               w_beat;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .i_req         (req_valid),
    .i_ptr         (r_rr_ptr),
    .o_grant       (w_grant),
    .o_grant_idx   (w_grant_idx),
    .o_grant_valid (w_grant_valid)
  );

  // Grant is offered only in IDLE and requesters hold valid, so any grant
  // there is an accept.
  assign w_accept = (r_state == ST_IDLE) && w_grant_valid;
  assign w_beat   = (r_state == ST_R) && RVALID && RREADY;

  always_comb begin
    w_sel_addr = '0;
    w_sel_len  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_idx == PTR_W'(i)) begin
        w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        w_sel_len  = req_len[i*LEN_W +: LEN_W];
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next_state = ST_AR;
      ST_AR:   if (ARREADY) w_next_state = ST_R;
      ST_R:    if (w_beat && RLAST) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Burst context: latched on accept, beat counter advances per transfer
  // and saturates so an over-long burst cannot wrap back onto len.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_beat_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_owner    <= w_grant_idx;
        r_addr     <= w_sel_addr & ADDR_MASK;
        r_len      <= w_sel_len;
        r_beat_cnt <= '0;
      end
      if (w_beat) begin
        if (r_beat_cnt != '1) r_beat_cnt <= r_beat_cnt + 1'b1;
        if (RLAST) begin
          r_rr_ptr <= (r_owner == PTR_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
        end
      end
    end
  end

  // AR fields are zero outside AR so nothing stale is visible on the bus.
  always_comb begin
    req_ready = '0;
    ARVALID   = 1'b0;
    ARID      = '0;
    ARADDR    = '0;
    ARLEN     = '0;
    ARSIZE    = '0;
    ARBURST   = '0;
    RREADY    = 1'b0;
    rsp_valid = '0;
    rsp_data  = RDATA;
    rsp_last  = RLAST;
    rsp_err   = (RRESP != RESP_OKAY) || (RID != ID_W'(r_owner)) ||
                (RLAST && (r_beat_cnt != r_len));
    case (r_state)
      ST_IDLE: req_ready = w_grant;
      ST_AR: begin
        ARVALID = 1'b1;
        ARID    = ID_W'(r_owner);
        ARADDR  = r_addr;
        ARLEN   = r_len;
        ARSIZE  = 3'(SIZE);
        ARBURST = AXI_BURST_INCR;
      end
      ST_R: begin
        RREADY             = rsp_ready[r_owner];
        rsp_valid[r_owner] = RVALID;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_l1c_axi_read_arbiter.sv
// Self-checking bench for l1c_axi_read_arbiter (NUM_REQ=2, 32-bit data).
// A per-cycle vector table covers single bursts, contention and errors;
// back-pressure, AR stall and mid-burst reset are hand-written sequences.
module tb_l1c_axi_read_arbiter;
  import l1c_axi_pkg::*;

  localparam logic [31:0] ADDR0    = 32'h1000_0004;
  localparam logic [31:0] ADDR1    = 32'h2000_0013;
  localparam logic [31:0] ADDR1_AL = 32'h2000_0010;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [63:0] req_addr;
  logic [7:0]  req_len;
  logic [31:0] rsp_data, ARADDR, RDATA;
  logic        rsp_last, rsp_err, ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [3:0]  ARID, ARLEN, RID;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST, RRESP;

  int checks = 0;
  int errors = 0;

  always #5 ACLK = ~ACLK;

  l1c_axi_read_arbiter #(
    .NUM_REQ(2), .ADDR_W(32), .DATA_W(32), .ID_W(4), .LEN_W(4)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY)
  );

  typedef struct {
    logic [31:0] doReset, reqValid, rspReady, arReady, rValid, rid, rresp, rlast, rdata;
    logic [31:0] expReqReady, expArValid, expArAddr, expArLen, expArId;
    logic [31:0] expRReady, expRspValid, expRspLast, expRspErr;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(
    logic [31:0] rst, rv, rr, arr, rvld, rid, rresp, rlast, rdata,
    logic [31:0] eRq, eAv, eAddr, eLen, eId, eRr, eRv, eLast, eErr);
    vec_t v;
    v.doReset = rst; v.reqValid = rv; v.rspReady = rr; v.arReady = arr;
    v.rValid = rvld; v.rid = rid; v.rresp = rresp; v.rlast = rlast; v.rdata = rdata;
    v.expReqReady = eRq; v.expArValid = eAv; v.expArAddr = eAddr; v.expArLen = eLen;
    v.expArId = eId; v.expRReady = eRr; v.expRspValid = eRv;
    v.expRspLast = eLast; v.expRspErr = eErr;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic driveIdle();
    req_valid = '0; rsp_ready = '0; ARREADY = 1'b0; RVALID = 1'b0;
    RID = '0; RRESP = RESP_OKAY; RLAST = 1'b0; RDATA = '0;
  endtask

  task automatic pulseReset();
    ARESETn = 1'b0;
    driveIdle();
    #1 ARESETn = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge ACLK);
    if (v.doReset[0]) pulseReset();
    req_valid = v.reqValid[1:0]; rsp_ready = v.rspReady[1:0];
    ARREADY = v.arReady[0]; RVALID = v.rValid[0]; RID = v.rid[3:0];
    RRESP = v.rresp[1:0]; RLAST = v.rlast[0]; RDATA = v.rdata;
    #1;
    checkOutput($sformatf("v%0d.reqReady", idx), 32'(req_ready), v.expReqReady);
    checkOutput($sformatf("v%0d.arValid", idx), 32'(ARVALID), v.expArValid);
    if (v.expArValid[0]) begin
      checkOutput($sformatf("v%0d.arAddr", idx), ARADDR, v.expArAddr);
      checkOutput($sformatf("v%0d.arLen", idx), 32'(ARLEN), v.expArLen);
      checkOutput($sformatf("v%0d.arId", idx), 32'(ARID), v.expArId);
      checkOutput($sformatf("v%0d.arSize", idx), 32'(ARSIZE), 32'd2);
      checkOutput($sformatf("v%0d.arBurst", idx), 32'(ARBURST), 32'd1);
    end
    checkOutput($sformatf("v%0d.rReady", idx), 32'(RREADY), v.expRReady);
    checkOutput($sformatf("v%0d.rspValid", idx), 32'(rsp_valid), v.expRspValid);
    if (v.expRspValid != 0) begin
      checkOutput($sformatf("v%0d.rspData", idx), rsp_data, v.rdata);
      checkOutput($sformatf("v%0d.rspLast", idx), 32'(rsp_last), v.expRspLast);
      checkOutput($sformatf("v%0d.rspErr", idx), 32'(rsp_err), v.expRspErr);
    end
  endtask

  initial begin
    logic [5:0] bpPat;
    int beat;

    req_addr = {ADDR1, ADDR0};
    req_len  = {4'd2, 4'd3};
    ARESETn  = 1'b0;
    driveIdle();

    // Single burst from requester 0, ARREADY immediate, four OKAY beats.
    addVec(0, 1, 0, 0, 0, 0, 0, 0, 0,          1, 0, 0, 0, 0, 0, 0, 0, 0);
    addVec(0, 0, 0, 1, 0, 0, 0, 0, 0,          0, 1, ADDR0, 3, 0, 0, 0, 0, 0);
    addVec(0, 0, 1, 0, 1, 0, 0, 0, 32'hA0,     0, 0, 0, 0, 0, 1, 1, 0, 0);
    addVec(0, 0, 1, 0, 1, 0, 0, 0, 32'hA1,     0, 0, 0, 0, 0, 1, 1, 0, 0);
    addVec(0, 0, 1, 0, 1, 0, 0, 0, 32'hA2,     0, 0, 0, 0, 0, 1, 1, 0, 0);
    addVec(0, 0, 1, 0, 1, 0, 0, 1, 32'hA3,     0, 0, 0, 0, 0, 1, 1, 1, 0);
    addVec(0, 0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Contention from reset: req0 first, then req1 although req0 re-requests.
    addVec(1, 3, 0, 0, 0, 0, 0, 0, 0,          1, 0, 0, 0, 0, 0, 0, 0, 0);
    addVec(0, 3, 0, 1, 0, 0, 0, 0, 0,          0, 1, ADDR0, 3, 0, 0, 0, 0, 0);
    addVec(0, 3, 3, 0, 1, 0, 0, 0, 32'hB0,     0, 0, 0, 0, 0, 1, 1, 0, 0);
    addVec(0, 3, 3, 0, 1, 0, 0, 0, 32'hB1,     0, 0, 0, 0, 0, 1, 1, 0, 0);
    addVec(0, 3, 3, 0, 1, 0, 0, 0, 32'hB2,     0, 0, 0, 0, 0, 1, 1, 0, 0);
    addVec(0, 3, 3, 0, 1, 0, 0, 1, 32'hB3,     0, 0, 0, 0, 0, 1, 1, 1, 0);
    addVec(0, 3, 0, 0, 0, 0, 0, 0, 0,          2, 0, 0, 0, 0, 0, 0, 0, 0);
    addVec(0, 1, 0, 1, 0, 0, 0, 0, 0,          0, 1, ADDR1_AL, 2, 1, 0, 0, 0, 0);
    addVec(0, 1, 2, 0, 1, 1, 0, 0, 32'hC0,     0, 0, 0, 0, 0, 1, 2, 0, 0);
    addVec(0, 1, 2, 0, 1, 1, 0, 0, 32'hC1,     0, 0, 0, 0, 0, 1, 2, 0, 0);
    addVec(0, 1, 2, 0, 1, 1, 0, 1, 32'hC2,     0, 0, 0, 0, 0, 1, 2, 1, 0);
    addVec(0, 3, 0, 0, 0, 0, 0, 0, 0,          1, 0, 0, 0, 0, 0, 0, 0, 0);
    // Errors: SLVERR beat, wrong RID beat, then an early RLAST burst.
    addVec(1, 1, 0, 0, 0, 0, 0, 0, 0,          1, 0, 0, 0, 0, 0, 0, 0, 0);
    addVec(0, 0, 0, 1, 0, 0, 0, 0, 0,          0, 1, ADDR0, 3, 0, 0, 0, 0, 0);
    addVec(0, 0, 1, 0, 1, 0, 0, 0, 32'hD0,     0, 0, 0, 0, 0, 1, 1, 0, 0);
    addVec(0, 0, 1, 0, 1, 0, RESP_SLVERR, 0, 32'hD1, 0, 0, 0, 0, 0, 1, 1, 0, 1);
    addVec(0, 0, 1, 0, 1, 3, 0, 0, 32'hD2,     0, 0, 0, 0, 0, 1, 1, 0, 1);
    addVec(0, 0, 1, 0, 1, 0, 0, 1, 32'hD3,     0, 0, 0, 0, 0, 1, 1, 1, 0);
    addVec(0, 1, 0, 0, 0, 0, 0, 0, 0,          1, 0, 0, 0, 0, 0, 0, 0, 0);
    addVec(0, 0, 0, 1, 0, 0, 0, 0, 0,          0, 1, ADDR0, 3, 0, 0, 0, 0, 0);
    addVec(0, 0, 1, 0, 1, 0, 0, 0, 32'hE0,     0, 0, 0, 0, 0, 1, 1, 0, 0);
    addVec(0, 0, 1, 0, 1, 0, 0, 1, 32'hE1,     0, 0, 0, 0, 0, 1, 1, 1, 1);
    addVec(0, 0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state.
    repeat (2) @(negedge ACLK);
    #1;
    checkOutput("rst.arValid", 32'(ARVALID), 0);
    checkOutput("rst.rReady", 32'(RREADY), 0);
    checkOutput("rst.reqReady", 32'(req_ready), 0);
    checkOutput("rst.rspValid", 32'(rsp_valid), 0);
    checkOutput("rst.arAddr", ARADDR, 0);
    checkOutput("rst.arLen", 32'(ARLEN), 0);
    checkOutput("rst.arId", 32'(ARID), 0);
    ARESETn = 1'b1;

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // Back-pressure on requester 1: RREADY must follow rsp_ready[1] only.
    @(negedge ACLK);
    pulseReset();
    req_valid = 2'b10;
    #1 checkOutput("bp.grant", 32'(req_ready), 32'b10);
    @(negedge ACLK);
    req_valid = 2'b00; ARREADY = 1'b1;
    #1 checkOutput("bp.arId", 32'(ARID), 1);
    bpPat = 6'b110001;
    beat = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge ACLK);
      ARREADY = 1'b0;
      rsp_ready = {bpPat[c], 1'b1};
      RVALID = 1'b1; RID = 4'd1; RDATA = 32'hF0 + 32'(beat); RLAST = (beat == 2);
      #1;
      checkOutput($sformatf("bp%0d.rReady", c), 32'(RREADY), 32'(bpPat[c]));
      checkOutput($sformatf("bp%0d.rspValid", c), 32'(rsp_valid), 32'b10);
      checkOutput($sformatf("bp%0d.rspData", c), rsp_data, 32'hF0 + 32'(beat));
      checkOutput($sformatf("bp%0d.rspErr", c), 32'(rsp_err), 0);
      if (bpPat[c]) beat++;
    end
    @(negedge ACLK);
    driveIdle();
    req_valid = 2'b11;
    #1 checkOutput("bp.nextGrant", 32'(req_ready), 32'b01);

    // ARREADY stall, then reset while in R.
    @(negedge ACLK);
    pulseReset();
    req_valid = 2'b01;
    #1 checkOutput("st.grant", 32'(req_ready), 32'b01);
    for (int c = 0; c < 5; c++) begin
      @(negedge ACLK);
      req_valid = 2'b00; ARREADY = 1'b0;
      #1;
      checkOutput($sformatf("st%0d.arValid", c), 32'(ARVALID), 1);
      checkOutput($sformatf("st%0d.arAddr", c), ARADDR, ADDR0);
    end
    @(negedge ACLK);
    ARREADY = 1'b1;
    #1 checkOutput("st.arValidHs", 32'(ARVALID), 1);
    @(negedge ACLK);
    ARREADY = 1'b0; rsp_ready = 2'b01; RVALID = 1'b1; RDATA = 32'h55;
    #1;
    checkOutput("st.rReady", 32'(RREADY), 1);
    checkOutput("st.rspValid", 32'(rsp_valid), 32'b01);
    checkOutput("st.arValidR", 32'(ARVALID), 0);
    #1 ARESETn = 1'b0;
    #1;
    checkOutput("mr.arValid", 32'(ARVALID), 0);
    checkOutput("mr.rReady", 32'(RREADY), 0);
    checkOutput("mr.rspValid", 32'(rsp_valid), 0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    driveIdle();
    req_valid = 2'b11;
    #1 checkOutput("mr.idleGrant", 32'(req_ready), 32'b01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
